// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the instruction/data SRAM port arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package sram_port_arbiter_pkg;

    // Data path width for addresses, read data and write data
    localparam int WORD_W = 32;

    // Default number of back-to-back data grants tolerated while a fetch waits
    localparam int STARVE_LIMIT_DEF = 2;

    // Arbiter state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_I = 3'd1,
        ST_RESP_I  = 3'd2,
        ST_ISSUE_D = 3'd3,
        ST_RESP_D  = 3'd4
    } state_t;

    // The SRAM is word addressed on byte addresses: drop the byte offset
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sram_port_arbiter_grant_counter.sv
// Free-running 32-bit event counter with synchronous clear and increment enable.
// Latency: count reflects an increment one cycle after i_inc is sampled.
// Backpressure: none; wraps from all-ones to zero.
module grant_counter
    import sram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [WORD_W-1:0] o_cnt
);

    logic [WORD_W-1:0] r_cnt;

    // Clear has priority; otherwise count enabled events with natural wrap
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + WORD_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between an instruction-fetch port and a data port.
// Latency: request seen in IDLE is issued next cycle and acked the cycle after (2 cycles).
// Backpressure: requesters hold req until ack; data has priority with a starvation cap for fetch.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [WORD_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic [WORD_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [WORD_W-1:0] data_addr,
    input  logic [WORD_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [WORD_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [WORD_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic [WORD_W-1:0] inst_grant_cnt,
    output logic [WORD_W-1:0] data_grant_cnt
);

    localparam logic [1:0] LIM = 2'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_starve_cnt;
    logic       w_inst_elig;
    logic       w_data_elig;
    logic       w_enter_i;
    logic       w_enter_d;

    // State register; reset abandons any access in flight without an ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an issue always turns into its response; otherwise arbitrate.
    // The port being acked this cycle is still holding req, so it is not eligible.
    always_comb begin
        w_inst_elig = inst_req && (r_state != ST_RESP_I);
        w_data_elig = data_req && (r_state != ST_RESP_D);
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_ISSUE_I: w_state_nxt = ST_RESP_I;
            ST_ISSUE_D: w_state_nxt = ST_RESP_D;
            default: begin
                if (w_inst_elig && (!w_data_elig || (r_starve_cnt == LIM))) begin
                    w_state_nxt = ST_ISSUE_I;
                end else if (w_data_elig) begin
                    w_state_nxt = ST_ISSUE_D;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign w_enter_i = (w_state_nxt == ST_ISSUE_I);
    assign w_enter_d = (w_state_nxt == ST_ISSUE_D);

    // Count data grants taken while a fetch is waiting; a fetch grant resets it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 2'd0;
        end else if (w_enter_i) begin
            r_starve_cnt <= 2'd0;
        end else if (w_enter_d && inst_req && (r_starve_cnt != LIM)) begin
            r_starve_cnt <= r_starve_cnt + 2'd1;
        end
    end

    // Outputs decoded from state; read data is steered straight from the SRAM
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'd0;
        sram_addr  = '0;
        sram_wdata = '0;
        inst_ack   = 1'b0;
        inst_rdata = '0;
        data_ack   = 1'b0;
        data_rdata = '0;
        case (r_state)
            ST_ISSUE_I: begin
                sram_en   = 1'b1;
                sram_addr = word_align(inst_addr);
            end
            ST_ISSUE_D: begin
                sram_en    = 1'b1;
                sram_wen   = data_wen;
                sram_addr  = word_align(data_addr);
                sram_wdata = data_wdata;
            end
            ST_RESP_I: begin
                inst_ack   = 1'b1;
                inst_rdata = sram_rdata;
            end
            ST_RESP_D: begin
                data_ack   = 1'b1;
                data_rdata = sram_rdata;
            end
            default: ;
        endcase
    end

    grant_counter u_inst_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (r_state == ST_RESP_I),
        .o_cnt (inst_grant_cnt)
    );

    grant_counter u_data_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (r_state == ST_RESP_D),
        .o_cnt (data_grant_cnt)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: cycle-level reference model predicts issues/acks.
// Latency: n/a.
// Backpressure: requesters hold req until they observe their ack.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int LIM    = 2;
    localparam int W_NONE = 0;
    localparam int W_I    = 1;
    localparam int W_D    = 2;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    sram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_ack       (inst_ack),
        .inst_rdata     (inst_rdata),
        .data_req       (data_req),
        .data_wen       (data_wen),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_ack       (data_ack),
        .data_rdata     (data_rdata),
        .sram_en        (sram_en),
        .sram_wen       (sram_wen),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] rdata;
    } ack_t;

    iss_t iss_q[$];
    ack_t iack_q[$];
    ack_t dack_q[$];

    logic [31:0] ref_mem  [256];
    logic [31:0] sram_mem [256];

    int          cyc;
    int          n_cmp;
    int          n_err;
    bit          mon_en;
    bit          saw_iack;
    bit          saw_dack;
    logic [31:0] nxt_rd;

    // Reference model: who issues / who is acked in the current cycle
    int          m_iss;
    int          m_rsp;
    int          nx_iss;
    int          nx_rsp;
    int          m_starve;
    logic [31:0] e_icnt_now, e_icnt_nxt, e_dcnt_now, e_dcnt_nxt;

    bit   mon_hit;
    iss_t mon_iss;
    ack_t mon_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural SRAM: one access per enabled cycle, read data the following cycle
    always @(negedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'd0) begin
                nxt_rd = sram_mem[sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) sram_mem[sram_addr[9:2]][8*b +: 8] = sram_wdata[8*b +: 8];
                nxt_rd = $urandom;
            end
        end else begin
            nxt_rd = $urandom;
        end
    end

    // Monitor: compare every DUT-presented issue/ack against the scoreboard queues
    always @(negedge clk) begin
        saw_iack = inst_ack;
        saw_dack = data_ack;
        if (mon_en) begin
            while (iss_q.size() > 0 && iss_q[0].cyc < cyc) iss_q.delete(0);
            while (iack_q.size() > 0 && iack_q[0].cyc < cyc) iack_q.delete(0);
            while (dack_q.size() > 0 && dack_q[0].cyc < cyc) dack_q.delete(0);

            mon_hit = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
            chk("sram_en", {31'd0, sram_en}, {31'd0, mon_hit});
            if (sram_en && mon_hit) begin
                mon_iss = iss_q.pop_front();
                chk("sram_addr", sram_addr, mon_iss.addr);
                chk("sram_wen", {28'd0, sram_wen}, {28'd0, mon_iss.wen});
                chk("sram_wdata", sram_wdata, mon_iss.wdata);
            end else if (!sram_en) begin
                chk("idle_addr", sram_addr, 32'd0);
                chk("idle_wen_wdata", sram_wdata | {28'd0, sram_wen}, 32'd0);
            end

            mon_hit = (iack_q.size() > 0) && (iack_q[0].cyc == cyc);
            chk("inst_ack", {31'd0, inst_ack}, {31'd0, mon_hit});
            if (inst_ack && mon_hit) begin
                mon_ack = iack_q.pop_front();
                chk("inst_rdata", inst_rdata, mon_ack.rdata);
            end else if (!inst_ack) begin
                chk("inst_rdata_idle", inst_rdata, 32'd0);
            end

            mon_hit = (dack_q.size() > 0) && (dack_q[0].cyc == cyc);
            chk("data_ack", {31'd0, data_ack}, {31'd0, mon_hit});
            if (data_ack && mon_hit) begin
                mon_ack = dack_q.pop_front();
                if (mon_ack.rd) chk("data_rdata", data_rdata, mon_ack.rdata);
            end else if (!data_ack) begin
                chk("data_rdata_idle", data_rdata, 32'd0);
            end

            chk("inst_grant_cnt", inst_grant_cnt, e_icnt_now);
            chk("data_grant_cnt", data_grant_cnt, e_dcnt_now);
        end
    end

    // Advance to the next cycle; requesters release after seeing their ack
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
        sram_rdata = nxt_rd;
        e_icnt_now = e_icnt_nxt;
        e_dcnt_now = e_dcnt_nxt;
        m_iss = nx_iss;
        m_rsp = nx_rsp;
        if (saw_iack) inst_req = 1'b0;
        if (saw_dack) data_req = 1'b0;
    endtask

    // Reference model step: decide what the next cycle does and queue expectations
    task automatic end_cycle();
        bit ci;
        bit cd;
        e_icnt_nxt = rst ? 32'd0 : e_icnt_now + ((m_rsp == W_I) ? 32'd1 : 32'd0);
        e_dcnt_nxt = rst ? 32'd0 : e_dcnt_now + ((m_rsp == W_D) ? 32'd1 : 32'd0);
        if (rst) begin
            // an access issued this cycle never gets its response
            if (m_iss == W_I && iack_q.size() > 0) iack_q.delete(iack_q.size() - 1);
            if (m_iss == W_D && dack_q.size() > 0) dack_q.delete(dack_q.size() - 1);
            nx_iss   = W_NONE;
            nx_rsp   = W_NONE;
            m_starve = 0;
        end else if (m_iss != W_NONE) begin
            nx_rsp = m_iss;
            nx_iss = W_NONE;
        end else begin
            nx_rsp = W_NONE;
            ci = inst_req && (m_rsp != W_I);
            cd = data_req && (m_rsp != W_D);
            if (ci && (!cd || m_starve == LIM)) begin
                nx_iss   = W_I;
                m_starve = 0;
                iss_q.push_back('{cyc + 1, 4'd0, inst_addr & ~32'd3, 32'd0});
                iack_q.push_back('{cyc + 2, 1'b1, ref_mem[inst_addr[9:2]]});
            end else if (cd) begin
                nx_iss = W_D;
                if (inst_req && m_starve < LIM) m_starve++;
                iss_q.push_back('{cyc + 1, data_wen, data_addr & ~32'd3, data_wdata});
                dack_q.push_back('{cyc + 2, data_wen == 4'd0, ref_mem[data_addr[9:2]]});
                for (int b = 0; b < 4; b++)
                    if (data_wen[b]) ref_mem[data_addr[9:2]][8*b +: 8] = data_wdata[8*b +: 8];
            end else begin
                nx_iss = W_NONE;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic gen_reqs(input int pct);
        if (!inst_req && ($urandom_range(99) < pct)) begin
            inst_req  = 1'b1;
            inst_addr = $urandom_range(1023);
        end
        if (!data_req && ($urandom_range(99) < pct)) begin
            data_req   = 1'b1;
            data_addr  = $urandom_range(1023);
            data_wen   = ($urandom_range(1) == 1) ? 4'd0 : 4'($urandom);
            data_wdata = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        inst_addr = '0; data_addr = '0; data_wdata = '0; data_wen = '0; sram_rdata = '0;
        cyc = 0; n_cmp = 0; n_err = 0; mon_en = 1'b0; saw_iack = 1'b0; saw_dack = 1'b0;
        nxt_rd = '0; m_iss = W_NONE; m_rsp = W_NONE; nx_iss = W_NONE; nx_rsp = W_NONE;
        m_starve = 0; e_icnt_now = '0; e_icnt_nxt = '0; e_dcnt_now = '0; e_dcnt_nxt = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = $urandom;
            sram_mem[i] = ref_mem[i];
        end
        ref_mem[8'h41]  = 32'h2409_0005;
        sram_mem[8'h41] = 32'h2409_0005;

        // reset: checks start once the first reset edge has been taken
        begin_cycle(); mon_en = 1'b1; end_cycle();
        begin_cycle(); end_cycle();
        begin_cycle(); rst = 1'b0; end_cycle();
        idle(1);

        // single fetch at 0x104
        begin_cycle(); inst_req = 1'b1; inst_addr = 32'h0000_0104; end_cycle();
        idle(4);

        // simultaneous fetch and full-word store: data goes first
        begin_cycle();
        inst_req = 1'b1; inst_addr = 32'h0000_03C8;
        data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h0000_0203; data_wdata = 32'hDEAD_BEEF;
        end_cycle();
        idle(6);

        // read the stored word back through the data port
        begin_cycle(); data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0200; end_cycle();
        idle(4);

        // sustained contention from both ports
        repeat (60) begin
            begin_cycle(); gen_reqs(100); end_cycle();
        end
        idle(8);

        // reset while a data access is being issued
        begin_cycle(); data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0010; end_cycle();
        begin_cycle(); rst = 1'b1; end_cycle();
        begin_cycle(); rst = 1'b0; end_cycle();
        idle(6);

        // random traffic with occasional reset
        repeat (1500) begin
            begin_cycle();
            rst = ($urandom_range(199) == 0);
            gen_reqs(40);
            end_cycle();
        end
        begin_cycle(); rst = 1'b0; end_cycle();
        idle(8);

        // data grant counter wrap
        begin_cycle();
        force dut.u_data_cnt.r_cnt = 32'hFFFF_FFFF;
        e_dcnt_now = 32'hFFFF_FFFF;
        #1;
        release dut.u_data_cnt.r_cnt;
        end_cycle();
        begin_cycle(); data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_0044; end_cycle();
        idle(5);

        chk("pending_issues", iss_q.size(), 32'd0);
        chk("pending_inst_acks", iack_q.size(), 32'd0);
        chk("pending_data_acks", dack_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
